// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single cache-controller memory port.
// Each transaction takes one BUSY phase, then one DONE cycle in which ready/err pulses to the winner.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int TIMEOUT    = 1023,
   parameter int FIXED_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_rd_en,
   input  logic          p0_wr_en,
   input  logic [AW-1:0] p0_address,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_ready,
   output logic          p0_err,
   input  logic          p1_rd_en,
   input  logic          p1_wr_en,
   input  logic [AW-1:0] p1_address,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_ready,
   output logic          p1_err,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          grant,
   output logic          busy
);

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WDOG_EN = (TIMEOUT != 0);
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WDOG_MAX  = {WW{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic          last_grant_r;
   logic [WW-1:0] wdog_r;
   logic          req0_s;
   logic          req1_s;
   logic          win_s;
   logic          win_rd_s;
   logic          win_wr_s;
   logic          take_s;
   logic          complete_s;
   logic          abort_s;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; the unused encoding falls back to IDLE
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE:    state_nxt_s = take_s ? BUSY : IDLE;
         BUSY:    state_nxt_s = (complete_s || abort_s) ? DONE : BUSY;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Arbitration and transaction events
   always_comb begin
      req0_s = p0_rd_en | p0_wr_en;
      req1_s = p1_rd_en | p1_wr_en;
      win_s  = 1'b0;
      if (req0_s && !req1_s) begin
         win_s = 1'b0;
      end else if (!req0_s && req1_s) begin
         win_s = 1'b1;
      end else if (FIXED_PRIO != 0) begin
         win_s = 1'b0;
      end else begin
         win_s = ~last_grant_r;
      end
      win_rd_s   = win_s ? p1_rd_en : p0_rd_en;
      win_wr_s   = win_s ? p1_wr_en : p0_wr_en;
      take_s     = (state_r == IDLE) && (req0_s || req1_s);
      complete_s = (state_r == BUSY) && mem_ready;
      abort_s    = (state_r == BUSY) && !mem_ready && WDOG_EN && (wdog_r == WDOG_LAST);
   end

   // Registered command, response and watchdog datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_rdata     <= {DW{1'b0}};
         p1_rdata     <= {DW{1'b0}};
         p0_ready     <= 1'b0;
         p1_ready     <= 1'b0;
         p0_err       <= 1'b0;
         p1_err       <= 1'b0;
         mem_rd_en    <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_address  <= {AW{1'b0}};
         mem_wdata    <= {DW{1'b0}};
         grant        <= 1'b0;
         busy         <= 1'b0;
         last_grant_r <= 1'b1;
         wdog_r       <= {WW{1'b0}};
      end else begin
         p0_ready <= 1'b0;
         p1_ready <= 1'b0;
         p0_err   <= 1'b0;
         p1_err   <= 1'b0;
         busy     <= (state_nxt_s == BUSY) || (state_nxt_s == DONE);
         if (take_s) begin
            grant        <= win_s;
            last_grant_r <= win_s;
            mem_address  <= win_s ? p1_address : p0_address;
            mem_wdata    <= win_s ? p1_wdata : p0_wdata;
            mem_wr_en    <= win_wr_s;
            mem_rd_en    <= win_rd_s & ~win_wr_s;
            wdog_r       <= {WW{1'b0}};
         end else if (complete_s) begin
            if (mem_rd_en && grant) begin
               p1_rdata <= mem_rdata;
            end else if (mem_rd_en) begin
               p0_rdata <= mem_rdata;
            end
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            p1_ready  <= grant;
            p0_ready  <= ~grant;
         end else if (abort_s) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            p1_err    <= grant;
            p0_err    <= ~grant;
         end else if (state_r == BUSY) begin
            // Saturate so a disabled watchdog never wraps
            if (wdog_r != WDOG_MAX) begin
               wdog_r <= wdog_r + WW'(1'b1);
            end
         end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share one stimulus stream
// and are both compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int TMO = 8;

   logic clk, rst;
   logic p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en, mem_ready;
   logic [31:0] p0_address, p0_wdata, p1_address, p1_wdata, mem_rdata;

   logic [1:0][31:0] d_p0_rdata, d_p1_rdata, d_mem_address, d_mem_wdata;
   logic [1:0] d_p0_ready, d_p1_ready, d_p0_err, d_p1_err;
   logic [1:0] d_mem_rd_en, d_mem_wr_en, d_grant, d_busy;

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .FIXED_PRIO(g)) dut (
         .clk(clk), .rst(rst),
         .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_address(p0_address), .p0_wdata(p0_wdata),
         .p0_rdata(d_p0_rdata[g]), .p0_ready(d_p0_ready[g]), .p0_err(d_p0_err[g]),
         .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_address(p1_address), .p1_wdata(p1_wdata),
         .p1_rdata(d_p1_rdata[g]), .p1_ready(d_p1_ready[g]), .p1_err(d_p1_err[g]),
         .mem_rd_en(d_mem_rd_en[g]), .mem_wr_en(d_mem_wr_en[g]),
         .mem_address(d_mem_address[g]), .mem_wdata(d_mem_wdata[g]),
         .mem_rdata(mem_rdata), .mem_ready(mem_ready),
         .grant(d_grant[g]), .busy(d_busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level view of one arbiter: who owns the port, how long it has waited,
   // and what each output should show.
   typedef struct {
      int               owner;
      bit               fin;
      int               waited;
      bit               last;
      logic [1:0][31:0] rdata;
      logic [1:0]       ready;
      logic [1:0]       err;
      logic             mrd;
      logic             mwr;
      logic [31:0]      addr;
      logic [31:0]      wdata;
      logic             grant;
   } model_t;

   model_t m [2];

   typedef struct {
      logic        rd0, wr0, rd1, wr1;
      logic [31:0] a0, a1, w0, w1, mdata;
      int          stall;
      logic [1:0]  eg;
      logic        mrd, mwr;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         m[g].owner = -1; m[g].fin = 1'b0; m[g].waited = 0; m[g].last = 1'b1;
         m[g].rdata = '0; m[g].ready = 2'b00; m[g].err = 2'b00;
         m[g].mrd = 1'b0; m[g].mwr = 1'b0; m[g].addr = 32'd0; m[g].wdata = 32'd0;
         m[g].grant = 1'b0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_step();
      logic [1:0] req;
      req = {p1_rd_en | p1_wr_en, p0_rd_en | p0_wr_en};
      for (int g = 0; g < 2; g++) begin
         m[g].ready = 2'b00;
         m[g].err   = 2'b00;
         if (m[g].fin) begin
            m[g].fin   = 1'b0;
            m[g].owner = -1;
         end else if (m[g].owner >= 0) begin
            if (mem_ready) begin
               if (m[g].mrd) m[g].rdata[m[g].owner] = mem_rdata;
               m[g].ready[m[g].owner] = 1'b1;
               m[g].mrd = 1'b0; m[g].mwr = 1'b0; m[g].fin = 1'b1;
            end else begin
               m[g].waited++;
               if (m[g].waited >= TMO) begin
                  m[g].err[m[g].owner] = 1'b1;
                  m[g].mrd = 1'b0; m[g].mwr = 1'b0; m[g].fin = 1'b1;
               end
            end
         end else if (req != 2'b00) begin
            int w;
            logic rd, wr;
            if (req == 2'b01) w = 0;
            else if (req == 2'b10) w = 1;
            else if (g == 1) w = 0;
            else w = m[g].last ? 0 : 1;
            rd = (w == 1) ? p1_rd_en : p0_rd_en;
            wr = (w == 1) ? p1_wr_en : p0_wr_en;
            m[g].owner = w; m[g].last = (w == 1); m[g].grant = (w == 1);
            m[g].addr  = (w == 1) ? p1_address : p0_address;
            m[g].wdata = (w == 1) ? p1_wdata : p0_wdata;
            m[g].mwr = wr; m[g].mrd = rd & ~wr; m[g].waited = 0;
         end
      end
   endtask

   function automatic logic [255:0] act_vec(int g);
      return {120'd0, d_p1_rdata[g], d_p0_rdata[g], d_p1_ready[g], d_p0_ready[g], d_p1_err[g], d_p0_err[g],
              d_mem_rd_en[g], d_mem_wr_en[g], d_mem_address[g], d_mem_wdata[g], d_grant[g], d_busy[g]};
   endfunction

   function automatic logic [255:0] exp_vec(int g);
      return {120'd0, m[g].rdata[1], m[g].rdata[0], m[g].ready[1], m[g].ready[0], m[g].err[1], m[g].err[0],
              m[g].mrd, m[g].mwr, m[g].addr, m[g].wdata, m[g].grant, (m[g].owner >= 0)};
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("model0", act_vec(0), exp_vec(0));
      chk("model1", act_vec(1), exp_vec(1));
   endtask

   task automatic set_port(input int p, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] w);
      if (p == 0) begin
         p0_rd_en = rd; p0_wr_en = wr; p0_address = a; p0_wdata = w;
      end else begin
         p1_rd_en = rd; p1_wr_en = wr; p1_address = a; p1_wdata = w;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL sim_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [1:0] act;
      logic [1:0] rw;
      // rd0 wr0 rd1 wr1 a0 a1 w0 w1 mdata stall eg{inst1,inst0} mrd mwr
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 2'b00, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h480, 32'h0, 32'h12345678, 32'hFFFF0000, 6, 2'b11, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0, 32'hA5A50001, 1, 2'b00, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h204, 32'h0, 32'h0, 32'h0000BEEF, 0, 2'b01, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h108, 32'h208, 32'h0, 32'h0, 32'h13579BDF, 3, 2'b00, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h440, 32'h0, 32'hCAFEF00D, 32'h0, 32'h77777777, 2, 2'b00, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0, 32'h0, 32'h0, TMO, 2'b00, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10C, 32'h20C, 32'h0, 32'h0, 32'h2468ACE0, 0, 2'b01, 1'b1, 1'b0};

      rst = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) chk("reset_state", act_vec(g), 256'd0);
      rst = 1'b1;

      // Directed transactions from the table
      for (int i = 0; i < 8; i++) begin
         vec_t v;
         v = tbl[i];
         set_port(0, v.rd0, v.wr0, v.a0, v.w0);
         set_port(1, v.rd1, v.wr1, v.a1, v.w1);
         mem_ready = 1'b0;
         tick();
         for (int g = 0; g < 2; g++) begin
            chk("grant", d_grant[g], v.eg[g]);
            chk("mem_rd_en", d_mem_rd_en[g], v.mrd);
            chk("mem_wr_en", d_mem_wr_en[g], v.mwr);
            chk("mem_address", d_mem_address[g], v.eg[g] ? v.a1 : v.a0);
            chk("mem_wdata", d_mem_wdata[g], v.eg[g] ? v.w1 : v.w0);
         end
         repeat (v.stall) tick();
         if (v.stall < TMO) begin
            mem_ready = 1'b1; mem_rdata = v.mdata;
            tick();
            mem_ready = 1'b0;
            for (int g = 0; g < 2; g++) begin
               chk("ready_pulse", v.eg[g] ? d_p1_ready[g] : d_p0_ready[g], 1'b1);
               if (v.mrd) chk("rdata", v.eg[g] ? d_p1_rdata[g] : d_p0_rdata[g], v.mdata);
            end
         end else begin
            for (int g = 0; g < 2; g++) begin
               chk("err_pulse", v.eg[g] ? d_p1_err[g] : d_p0_err[g], 1'b1);
               chk("abort_rd_en", d_mem_rd_en[g], 1'b0);
            end
         end
         set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
         set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
         tick();
      end

      // Continuous tie: round-robin alternates, fixed priority keeps port 0
      set_port(0, 1'b1, 1'b0, 32'h300, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'h380, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_grant", d_grant[0], (k % 2 == 1));
         chk("fixed_grant", d_grant[1], 1'b0);
         mem_ready = 1'b1; mem_rdata = 32'h5000 + k;
         tick();
         mem_ready = 1'b0;
         tick();
      end
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();

      // mem_ready while idle must not produce a pulse
      mem_ready = 1'b1;
      tick();
      tick();
      for (int g = 0; g < 2; g++) chk("idle_ready", {d_p1_ready[g], d_p0_ready[g], d_busy[g]}, 3'b000);
      mem_ready = 1'b0;

      // Asynchronous reset in the middle of a transaction
      set_port(0, 1'b1, 1'b0, 32'h900, 32'd0);
      tick();
      for (int g = 0; g < 2; g++) chk("busy_before_reset", d_busy[g], 1'b1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      for (int g = 0; g < 2; g++) chk("reset_midbusy", act_vec(g), 256'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) chk("reset_held", act_vec(g), 256'd0);
      rst = 1'b1;
      set_port(1, 1'b1, 1'b0, 32'h940, 32'd0);
      tick();
      for (int g = 0; g < 2; g++) chk("first_grant_after_reset", d_grant[g], 1'b0);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_ready = 1'b0;
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();

      // Randomised traffic; requesters hold until they see their pulse in the round-robin model
      act = 2'b00;
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (act[p]) begin
               if (m[0].ready[p] || m[0].err[p] || $urandom_range(0, 49) == 0) begin
                  act[p] = 1'b0;
                  set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
               end
            end else if ($urandom_range(0, 2) == 0) begin
               act[p] = 1'b1;
               rw = 2'($urandom_range(1, 3));
               set_port(p, rw[0], rw[1], $urandom, $urandom);
            end
         end
         mem_ready = ($urandom_range(0, 9) < 3);
         mem_rdata = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
